sram_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between the CPU instruction fetch (F stage) and the

---
 rtl/sram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Runs one bus transaction at a time and holds each result until the pipeline advances.
module sram_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          i_stall,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_sel,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          d_stall,
  input  logic          longest_stall,
  input  logic          flush,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [3:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_WAIT = 3'd2,
    I_ADDR = 3'd3,
    I_WAIT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          inst_done_q, inst_done_d;
  logic          data_done_q, data_done_d;
  logic          discard_q, discard_d;
  logic [DW-1:0] inst_rdata_q, inst_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;

  logic i_pend, d_pend;
  logic inst_cap, data_cap;
  logic set_i, set_d, clr_done;

  assign i_pend     = inst_req & ~inst_done_q;
  assign d_pend     = data_req & ~data_done_q;
  assign i_stall    = i_pend;
  assign d_stall    = d_pend;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // Sequencer: data goes first since it belongs to the older instruction.
  // Bus controls read as zero whenever no request is being presented.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_sel   = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    inst_cap  = 1'b0;
    data_cap  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_pend) begin
          state_d = D_ADDR;
        end else if (i_pend) begin
          state_d = I_ADDR;
        end
      end
      D_ADDR: begin
        mem_req   = 1'b1;
        mem_wr    = data_wr;
        mem_sel   = data_wr ? data_sel : 4'hF;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        if (mem_addr_ok) begin
          state_d = D_WAIT;
        end
      end
      D_WAIT: begin
        if (mem_data_ok) begin
          data_cap = 1'b1;
          state_d  = IDLE;
        end
      end
      I_ADDR: begin
        mem_req  = 1'b1;
        mem_sel  = 4'hF;
        mem_addr = inst_addr;
        if (mem_addr_ok) begin
          state_d = I_WAIT;
        end
      end
      I_WAIT: begin
        if (mem_data_ok) begin
          inst_cap = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A result arriving under a pending or simultaneous flush is captured but never marked done.
  always_comb begin
    set_i        = inst_cap & ~discard_q & ~flush;
    set_d        = data_cap & ~discard_q & ~flush;
    clr_done     = flush | ~longest_stall;
    inst_done_d  = set_i ? 1'b1 : (clr_done ? 1'b0 : inst_done_q);
    data_done_d  = set_d ? 1'b1 : (clr_done ? 1'b0 : data_done_q);
    inst_rdata_d = inst_cap ? mem_rdata : inst_rdata_q;
    data_rdata_d = data_cap ? mem_rdata : data_rdata_q;
    if (inst_cap | data_cap) begin
      discard_d = 1'b0;
    end else if (flush && (state_q != IDLE)) begin
      discard_d = 1'b1;
    end else begin
      discard_d = discard_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      discard_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      discard_q    <= discard_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_sram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, data_req, data_wr, longest_stall, flush;
  logic [AW-1:0] inst_addr, data_addr;
  logic [3:0]    data_sel;
  logic [DW-1:0] data_wdata, mem_rdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata, mem_wdata;
  logic          i_stall, d_stall, mem_req, mem_wr;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .d_stall(d_stall),
    .longest_stall(longest_stall), .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_sel = 4'h0;
    data_addr = '0; data_wdata = '0; longest_stall = 1; flush = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    n_tests++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
    n_tests++; if (mem_sel !== 4'h0) begin n_fail++; $display("FAIL rst_mem_sel got %h want 0", mem_sel); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_tests++; if ({i_stall, d_stall} !== 2'b00) begin n_fail++; $display("FAIL rst_stalls got %b want 00", {i_stall, d_stall}); end
    n_tests++; if (inst_rdata !== '0 || data_rdata !== '0) begin n_fail++; $display("FAIL rst_rdata got %h/%h want 0/0", inst_rdata, data_rdata); end
  endtask

  task automatic test_fetch();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00000; #2;
    n_tests++; if (i_stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_c0 got stall=%b req=%b want 1/0", i_stall, mem_req); end
    tick(); mem_addr_ok = 1; #2;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00000 || mem_wr !== 1'b0 || mem_sel !== 4'hF) begin n_fail++; $display("FAIL fetch_c1 got req=%b addr=%h wr=%b sel=%h want 1/bfc00000/0/f", mem_req, mem_addr, mem_wr, mem_sel); end
    n_tests++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c1 got %b want 1", i_stall); end
    tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h24010001; #2;
    n_tests++; if (mem_req !== 1'b0 || i_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_c2 got req=%b stall=%b want 0/1", mem_req, i_stall); end
    tick(); mem_data_ok = 0; mem_rdata = '0; #2;
    n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c3 got %b want 0", i_stall); end
    n_tests++; if (inst_rdata !== 32'h24010001) begin n_fail++; $display("FAIL fetch_rdata got %h want 24010001", inst_rdata); end
  endtask

  task automatic test_priority();
    do_reset();
    data_req = 1; data_wr = 0; data_addr = 32'h80000010; data_sel = 4'h1;
    inst_req = 1; inst_addr = 32'hBFC00004; #2;
    n_tests++; if ({i_stall, d_stall} !== 2'b11) begin n_fail++; $display("FAIL prio_c0 got %b want 11", {i_stall, d_stall}); end
    tick(); mem_addr_ok = 1; #2;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80000010 || mem_wr !== 1'b0 || mem_sel !== 4'hF) begin n_fail++; $display("FAIL prio_data_first got req=%b addr=%h wr=%b sel=%h", mem_req, mem_addr, mem_wr, mem_sel); end
    tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFE0001; #2;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL prio_c2_req got %b want 0", mem_req); end
    tick(); mem_data_ok = 0; #2;
    n_tests++; if ({i_stall, d_stall} !== 2'b10) begin n_fail++; $display("FAIL prio_c3_stalls got %b want 10", {i_stall, d_stall}); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL prio_c3_no_req got %b want 0", mem_req); end
    n_tests++; if (data_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL prio_drdata got %h want cafe0001", data_rdata); end
    tick(); mem_addr_ok = 1; #2;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00004) begin n_fail++; $display("FAIL prio_fetch_c4 got req=%b addr=%h", mem_req, mem_addr); end
    tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h00000021; #2;
    tick(); mem_data_ok = 0; #2;
    n_tests++; if (i_stall !== 1'b0 || inst_rdata !== 32'h00000021) begin n_fail++; $display("FAIL prio_fetch_done got stall=%b rdata=%h", i_stall, inst_rdata); end
  endtask

  task automatic test_store_wait();
    do_reset();
    data_req = 1; data_wr = 1; data_sel = 4'b0011; data_wdata = 32'h0000BEEF; data_addr = 32'h80000020;
    for (int c = 1; c <= 5; c++) begin
      tick(); mem_addr_ok = (c == 5); #2;
      n_tests++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_sel !== 4'b0011 || mem_addr !== 32'h80000020 || mem_wdata !== 32'h0000BEEF) begin
        n_fail++; $display("FAIL store_hold_c%0d got req=%b wr=%b sel=%h addr=%h wdata=%h", c, mem_req, mem_wr, mem_sel, mem_addr, mem_wdata);
      end
    end
    tick(); mem_addr_ok = 0; mem_data_ok = 1; #2;
    n_tests++; if (d_stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL store_wait got stall=%b req=%b want 1/0", d_stall, mem_req); end
    tick(); mem_data_ok = 0; #2;
    n_tests++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL store_done got %b want 0", d_stall); end
  endtask

  task automatic test_done_hold();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00010;
    tick(); mem_addr_ok = 1;
    tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h8C020004;
    tick(); mem_data_ok = 0; mem_rdata = 32'hFFFFFFFF;
    for (int c = 3; c <= 5; c++) begin
      #2;
      n_tests++;
      if (mem_req !== 1'b0 || i_stall !== 1'b0 || inst_rdata !== 32'h8C020004) begin
        n_fail++; $display("FAIL hold_c%0d got req=%b stall=%b rdata=%h", c, mem_req, i_stall, inst_rdata);
      end
      tick();
    end
    longest_stall = 0; #2;
    n_tests++; if (i_stall !== 1'b0) begin n_fail++; $display("FAIL hold_release_c6 got %b want 0", i_stall); end
    tick(); longest_stall = 1; #2;
    n_tests++; if (i_stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_cleared_c7 got stall=%b req=%b want 1/0", i_stall, mem_req); end
  endtask

  task automatic test_flush();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00100;
    tick(); mem_addr_ok = 1;
    tick(); mem_addr_ok = 0; flush = 1; #2;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_c2_req got %b want 0", mem_req); end
    tick(); flush = 0; inst_addr = 32'hBFC00380; mem_data_ok = 1; mem_rdata = 32'hDEAD0000; #2;
    n_tests++; if (mem_req !== 1'b0 || i_stall !== 1'b1) begin n_fail++; $display("FAIL flush_c3 got req=%b stall=%b want 0/1", mem_req, i_stall); end
    tick(); mem_data_ok = 0; #2;
    n_tests++; if (i_stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_not_done got stall=%b req=%b want 1/0", i_stall, mem_req); end
    tick(); #2;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00380) begin n_fail++; $display("FAIL flush_refetch got req=%b addr=%h want 1/bfc00380", mem_req, mem_addr); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00200;
    tick(); mem_addr_ok = 1;
    tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234ABCD;
    tick(); mem_data_ok = 0; inst_req = 0; longest_stall = 0; #2;
    n_tests++; if (inst_rdata !== 32'h1234ABCD) begin n_fail++; $display("FAIL rstmid_pre_rdata got %h want 1234abcd", inst_rdata); end
    tick(); longest_stall = 1; data_req = 1; data_wr = 0; data_addr = 32'h80000040;
    tick(); #2;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80000040) begin n_fail++; $display("FAIL rstmid_daddr got req=%b addr=%h", mem_req, mem_addr); end
    rst = 1;
    tick(); #2;
    n_tests++; if (mem_req !== 1'b0 || d_stall !== 1'b1 || i_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got req=%b dst=%b ist=%b want 0/1/0", mem_req, d_stall, i_stall); end
    n_tests++; if (inst_rdata !== '0 || data_rdata !== '0) begin n_fail++; $display("FAIL rstmid_rdata got %h/%h want 0/0", inst_rdata, data_rdata); end
    rst = 0;
  endtask

  // Reference model: one outstanding transaction record (kind, address accepted, discard)
  // plus per-requester done flags and held results.
  task automatic test_random(input int ncyc);
    bit            busy, is_d, acc, disc, idone, ddone, fin, ip, dp, e_req, set_i, set_d;
    logic [DW-1:0] irq, drq, e_wdata;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_sel;
    logic          e_wr;
    busy = 0; is_d = 0; acc = 0; disc = 0; idone = 0; ddone = 0; irq = '0; drq = '0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      inst_req      = ($urandom_range(0, 3) != 0);
      inst_addr     = $urandom;
      data_req      = ($urandom_range(0, 2) == 0);
      data_wr       = $urandom_range(0, 1);
      data_sel      = 4'($urandom);
      data_addr     = $urandom;
      data_wdata    = $urandom;
      longest_stall = ($urandom_range(0, 2) != 0);
      e_req         = busy & ~acc;
      mem_addr_ok   = e_req & ($urandom_range(0, 1) == 1);
      mem_data_ok   = busy & acc & ($urandom_range(0, 2) != 0);
      mem_rdata     = $urandom;
      flush         = ~mem_data_ok & ($urandom_range(0, 15) == 0);
      #2;
      ip      = inst_req & ~idone;
      dp      = data_req & ~ddone;
      e_wr    = e_req & is_d & data_wr;
      e_sel   = !e_req ? 4'h0 : (is_d && data_wr) ? data_sel : 4'hF;
      e_addr  = !e_req ? '0 : is_d ? data_addr : inst_addr;
      e_wdata = (e_req && is_d) ? data_wdata : '0;
      n_tests++; if (mem_req !== e_req) begin n_fail++; $display("FAIL rnd_req cyc %0d got %b want %b", c, mem_req, e_req); end
      n_tests++; if (mem_wr !== e_wr || mem_sel !== e_sel) begin n_fail++; $display("FAIL rnd_wr_sel cyc %0d got %b/%h want %b/%h", c, mem_wr, mem_sel, e_wr, e_sel); end
      n_tests++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_addr_wdata cyc %0d got %h/%h want %h/%h", c, mem_addr, mem_wdata, e_addr, e_wdata); end
      n_tests++; if (i_stall !== ip || d_stall !== dp) begin n_fail++; $display("FAIL rnd_stalls cyc %0d got %b%b want %b%b", c, i_stall, d_stall, ip, dp); end
      n_tests++; if (inst_rdata !== irq || data_rdata !== drq) begin n_fail++; $display("FAIL rnd_rdata cyc %0d got %h/%h want %h/%h", c, inst_rdata, data_rdata, irq, drq); end
      fin   = busy & acc & mem_data_ok;
      set_i = fin & ~is_d & ~disc & ~flush;
      set_d = fin & is_d & ~disc & ~flush;
      if (fin && is_d) drq = mem_rdata;
      if (fin && !is_d) irq = mem_rdata;
      idone = set_i ? 1'b1 : (flush || !longest_stall) ? 1'b0 : idone;
      ddone = set_d ? 1'b1 : (flush || !longest_stall) ? 1'b0 : ddone;
      disc  = fin ? 1'b0 : (flush && busy) ? 1'b1 : disc;
      if (!busy) begin
        if (dp) begin busy = 1; is_d = 1; acc = 0; end
        else if (ip) begin busy = 1; is_d = 0; acc = 0; end
      end else if (!acc) begin
        acc = mem_addr_ok;
      end else if (mem_data_ok) begin
        busy = 0;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_fetch();
    test_priority();
    test_store_wait();
    test_done_hold();
    test_flush();
    test_rst_mid();
    test_random(4000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
